// File: rtl/io_port_ctrl.sv
// Board-side picoMIPS I/O: synchronises and debounces the push button, latches the
// switches into inport once per debounced press, and registers outport onto the LEDs.
`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif

module io_port_ctrl #(
  parameter int n         = `DATA_BUS_SIZE,
  parameter int DB_CYCLES = 50000,
  localparam int CW       = $clog2(DB_CYCLES)
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic [n-1:0] sw,
  input  logic         btn,
  input  logic [n-1:0] outport,
  output logic [n-1:0] inport,
  output logic         in_strobe,
  output logic         in_valid,
  output logic [n-1:0] leds
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [n-1:0]  sw_s1, sw_s;
  logic          btn_s1, btn_s;
  state_t        state;
  logic [CW-1:0] cnt;

  // Plain two-flop chains: nothing may sit between the stages or metastability leaks through.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sw_s1  <= '0;
      sw_s   <= '0;
      btn_s1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sw_s1  <= sw;
      sw_s   <= sw_s1;
      btn_s1 <= btn;
      btn_s  <= btn_s1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) leds <= '0;
    else         leds <= outport;
  end

  // Debounce FSM; capture happens only on the PRESS_WAIT -> HELD transition.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      cnt       <= '0;
      inport    <= '0;
      in_strobe <= 1'b0;
      in_valid  <= 1'b0;
    end else begin
      in_strobe <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            state     <= HELD;
            inport    <= sw_s;
            in_strobe <= 1'b1;
            in_valid  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl (n=8, DB_CYCLES=4): expected captures are queued at
// stimulus time and a negedge monitor pops and checks them whenever in_strobe is seen.
module tb_io_port_ctrl;

  localparam int N  = 8;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         nReset;
  logic [N-1:0] sw;
  logic         btn;
  logic [N-1:0] outport;
  logic [N-1:0] inport;
  logic         in_strobe;
  logic         in_valid;
  logic [N-1:0] leds;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  logic [N-1:0] exp_q[$];

  io_port_ctrl #(.n(N), .DB_CYCLES(DB)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .sw        (sw),
    .btn       (btn),
    .outport   (outport),
    .inport    (inport),
    .in_strobe (in_strobe),
    .in_valid  (in_valid),
    .leds      (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic edges(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued capture.
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (in_strobe) begin
      strobes++;
      check("strobe_width", {31'd0, prev_strobe}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {31'd0, in_strobe}, 32'd0);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        check("sb_inport", {24'd0, inport}, {24'd0, e});
        check("sb_in_valid", {31'd0, in_valid}, 32'd1);
      end
    end
    prev_strobe = in_strobe;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nReset  = 1'b0;
    sw      = 8'hFF;
    btn     = 1'b1;
    outport = 8'h55;
    #1;
    check("rst_inport_t0", {24'd0, inport}, 32'h0);
    check("rst_leds_t0", {24'd0, leds}, 32'h0);
    edges(4);
    check("rst_inport", {24'd0, inport}, 32'h0);
    check("rst_strobe", {31'd0, in_strobe}, 32'h0);
    check("rst_valid", {31'd0, in_valid}, 32'h0);
    check("rst_leds", {24'd0, leds}, 32'h0);

    // Clean press with exact latency.
    nReset = 1'b1;
    btn    = 1'b0;
    sw     = 8'hA5;
    edges(3);
    check("leds_after_rst", {24'd0, leds}, 32'h55);
    exp_q.push_back(8'hA5);
    btn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      edges(1);
      check($sformatf("press_strobe_e%0d", k), {31'd0, in_strobe}, {31'd0, (k == 7)});
      check($sformatf("press_inport_e%0d", k), {24'd0, inport}, (k >= 7) ? 32'hA5 : 32'h0);
      check($sformatf("press_valid_e%0d", k), {31'd0, in_valid}, {31'd0, (k >= 7)});
    end
    btn = 1'b0;
    edges(8);

    // Press bounce: never stable long enough to capture.
    sw = 8'h3C;
    for (int r = 0; r < 5; r++) begin
      btn = 1'b1;
      edges(3);
      btn = 1'b0;
      edges(1);
    end
    check("bounce_inport", {24'd0, inport}, 32'hA5);
    exp_q.push_back(8'h3C);
    btn = 1'b1;
    edges(9);
    check("bounce_capture", {24'd0, inport}, 32'h3C);

    // Release bounce must not re-capture; full release then a new press.
    for (int r = 0; r < 3; r++) begin
      btn = 1'b0;
      edges(2);
      btn = 1'b1;
      edges(1);
    end
    check("rel_bounce_inport", {24'd0, inport}, 32'h3C);
    btn = 1'b0;
    edges(8);
    sw = 8'h0F;
    exp_q.push_back(8'h0F);
    btn = 1'b1;
    edges(9);
    check("repress_inport", {24'd0, inport}, 32'h0F);
    btn = 1'b0;
    edges(8);

    // Switch change while held is ignored.
    sw = 8'h11;
    exp_q.push_back(8'h11);
    btn = 1'b1;
    edges(9);
    check("hold_capture", {24'd0, inport}, 32'h11);
    sw = 8'h22;
    edges(10);
    check("hold_sw_change", {24'd0, inport}, 32'h11);
    btn = 1'b0;
    edges(8);

    // LED path latency.
    outport = 8'hC3;
    #1;
    check("leds_before_edge", {24'd0, leds}, 32'h55);
    edges(1);
    check("leds_after_edge", {24'd0, leds}, 32'hC3);

    // Reset during PRESS_WAIT; held button is then debounced from scratch.
    sw  = 8'h77;
    btn = 1'b1;
    edges(4);
    nReset = 1'b0;
    #1;
    check("midrst_leds", {24'd0, leds}, 32'h0);
    check("midrst_inport", {24'd0, inport}, 32'h0);
    check("midrst_valid", {31'd0, in_valid}, 32'h0);
    check("midrst_strobe", {31'd0, in_strobe}, 32'h0);
    edges(2);
    nReset = 1'b1;
    #1;
    check("post_rst_leds_hold", {24'd0, leds}, 32'h0);
    exp_q.push_back(8'h77);
    edges(1);
    check("post_rst_leds", {24'd0, leds}, 32'hC3);
    for (int k = 2; k <= 7; k++) begin
      edges(1);
      check($sformatf("post_rst_valid_e%0d", k), {31'd0, in_valid}, {31'd0, (k >= 7)});
    end
    check("post_rst_inport", {24'd0, inport}, 32'h77);
    btn = 1'b0;
    edges(8);

    check("sb_queue_empty", exp_q.size(), 32'd0);
    check("strobe_count", strobes, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
